// File: rtl/gpio_lut_loader.sv
// gpio_lut_loader: turns byte-wide GPIO register writes into word-wide LUT writes
//   clk, rst      : system clock, asynchronous active-low reset
//   gpio_in       : [24] w_clk (async strobe), [23:16] data byte, [15:0] register address
//   lut_wr_en     : one-hot, one-cycle write strobe per channel
//   lut_wr_addr   : LUT index, valid with lut_wr_en, held until the next commit
//   lut_wr_data   : LUT word, valid with lut_wr_en, held until the next commit
//   status        : [15:0] commit count, [16] seq_err, [17] addr_ovf, [18] auto_inc, [22:19] last channel
module gpio_lut_loader #(
  parameter int NUM_CH = 6,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0040
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       gpio_in,
  output logic [NUM_CH-1:0] lut_wr_en,
  output logic [ADDR_W-1:0] lut_wr_addr,
  output logic [DATA_W-1:0] lut_wr_data,
  output logic [31:0]       status
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ADDR, DATA, COMMIT} state_t;
  state_t state, nxt;
  logic s1, s2, s3, ev, pend, go, wr, is_d, is_ctrl, clr, err, ld_hi, ld_lo, shf, fin, ovf;
  logic auto_inc, seq_err, addr_ovf, unused;
  logic [23:0] pbuf, wv;
  logic [15:0] off, addr_q, cnt, hi_bits;
  logic [7:0] wb;
  logic [3:0] wch, cur_ch, last_ch;
  logic [2:0] db;
  logic [DATA_W-1:0] word, nword;
  assign ev = s2 & ~s3;
  // an event landing on the COMMIT cycle is parked in pbuf and replayed one cycle later
  assign go = state != COMMIT && (ev || pend);
  assign wv = pend ? pbuf : gpio_in[23:0];
  assign wb = wv[23:16];
  assign off = wv[15:0] - BASE_ADDR;
  assign wch = off[4:1];
  assign is_d = off[0];
  assign wr = go && off < 16'(2 * NUM_CH);
  assign is_ctrl = go && off == 16'(2 * NUM_CH);
  assign clr = is_ctrl && wb[0];
  assign fin = db == 3'(NB - 1);
  assign nword = (word << 8) | DATA_W'(wb);
  // the index is legal when bits [15:ADDR_W-1] are all zeros or all ones
  assign hi_bits = addr_q >> (ADDR_W - 1);
  assign ovf = hi_bits != 16'h0 && hi_bits != (16'hFFFF >> (ADDR_W - 1));
  assign status = {9'h0, last_ch, auto_inc, addr_ovf, seq_err, cnt};
  assign unused = ^gpio_in[31:25];
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  // an addr write is a low byte only when it follows a high byte of the same channel;
  // every other addr write restarts the word as a high byte
  always_comb begin
    nxt = state;
    err = 1'b0;
    ld_hi = 1'b0;
    ld_lo = 1'b0;
    shf = 1'b0;
    if (state == COMMIT) nxt = auto_inc ? DATA : IDLE;
    else if (wr && !is_d) begin
      ld_lo = state == ADDR && wch == cur_ch;
      ld_hi = !ld_lo;
      err = (state == ADDR && wch != cur_ch) || (state == DATA && db != 3'd0);
      nxt = ld_lo ? DATA : ADDR;
    end else if (wr) begin
      shf = state == DATA && wch == cur_ch;
      err = !shf;
      nxt = !shf ? IDLE : fin ? COMMIT : DATA;
    end
    if (clr) nxt = IDLE;
  end
  always_comb lut_wr_en = state == COMMIT ? NUM_CH'(1) << cur_ch : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1, s2, s3, pend} <= '0;
      pbuf <= '0;
      addr_q <= '0;
      cnt <= '0;
      word <= '0;
      db <= '0;
      cur_ch <= '0;
      last_ch <= '0;
      seq_err <= 1'b0;
      addr_ovf <= 1'b0;
      auto_inc <= 1'b0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
    end else begin
      {s1, s2, s3} <= {gpio_in[24], s1, s2};
      pend <= state == COMMIT && ev;
      if (ev) pbuf <= gpio_in[23:0];
      if (is_ctrl) auto_inc <= wb[1];
      if (err) seq_err <= 1'b1;
      if (ld_hi) begin
        addr_q[15:8] <= wb;
        cur_ch <= wch;
      end
      if (ld_lo) addr_q[7:0] <= wb;
      if (ld_hi || ld_lo) db <= '0;
      if (shf) begin
        word <= nword;
        db <= db + 3'd1;
      end
      if (shf && fin) begin
        lut_wr_addr <= addr_q[ADDR_W-1:0];
        lut_wr_data <= nword;
      end
      if (state == COMMIT) begin
        cnt <= cnt + 16'(cnt != 16'hFFFF);
        addr_ovf <= addr_ovf | ovf;
        last_ch <= cur_ch;
        db <= '0;
        if (auto_inc) addr_q <= addr_q + 16'd1;
      end
      if (clr) begin
        cnt <= '0;
        seq_err <= 1'b0;
        addr_ovf <= 1'b0;
        db <= '0;
      end
    end
  end
endmodule

// File: tb/tb_gpio_lut_loader.sv
// tb_gpio_lut_loader: randomized and directed checks of gpio_lut_loader against a protocol-level model
module tb_gpio_lut_loader;
  localparam int NC = 6, AW = 8, DW = 16, NC2 = 9, DW2 = 24;
  localparam logic [15:0] BASE = 16'h0040;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] gi = '0, gi2 = '0;
  logic [NC-1:0] en;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [31:0] st;
  logic [NC2-1:0] en2;
  logic [AW-1:0] wa2;
  logic [DW2-1:0] wd2;
  logic [31:0] st2;
  int n_chk = 0, n_fail = 0;
  int m_ab, m_db, m_cur, m_cnt, m_last;
  logic m_err, m_ovf, m_auto;
  logic [15:0] m_addr, m_wa;
  logic [31:0] m_word, m_wd;
  logic [63:0] exp_q[$], obs[$], obs2[$], last_obs;
  always #5 clk = ~clk;
  gpio_lut_loader dut (
    .clk(clk), .rst(rst), .gpio_in(gi),
    .lut_wr_en(en), .lut_wr_addr(wa), .lut_wr_data(wd), .status(st)
  );
  gpio_lut_loader #(.NUM_CH(NC2), .DATA_W(DW2)) dut2 (
    .clk(clk), .rst(rst), .gpio_in(gi2),
    .lut_wr_en(en2), .lut_wr_addr(wa2), .lut_wr_data(wd2), .status(st2)
  );
  always @(negedge clk) begin
    if (|en) obs.push_back({16'(en), 16'(wa), 32'(wd)});
    if (|en2) obs2.push_back({16'(en2), 16'(wa2), 32'(wd2)});
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] mstat();
    return {9'h0, 4'(m_last), m_auto, m_ovf, m_err, 16'(m_cnt)};
  endfunction
  task automatic mwrite(input int u, input logic [15:0] ra, input logic [7:0] b);
    int n, nb, ch, sa;
    logic [15:0] off;
    n = u != 0 ? NC2 : NC;
    nb = (u != 0 ? DW2 : DW) / 8;
    off = ra - BASE;
    ch = int'(off) / 2;
    if (int'(off) == 2 * n) begin
      m_auto = b[1];
      if (b[0]) begin
        m_cnt = 0; m_err = 0; m_ovf = 0; m_ab = 0; m_db = 0;
      end
    end else if (int'(off) < 2 * n) begin
      if (!off[0]) begin
        if (m_ab == 1 && ch == m_cur) begin
          m_addr[7:0] = b; m_ab = 2; m_db = 0;
        end else begin
          if (m_ab == 1 || (m_ab == 2 && m_db != 0)) m_err = 1;
          m_addr[15:8] = b; m_cur = ch; m_ab = 1; m_db = 0;
        end
      end else if (m_ab == 2 && ch == m_cur) begin
        m_word = 32'((({32'h0, m_word} << 8) | 64'(b)) & ((64'd1 << (8 * nb)) - 64'd1));
        m_db++;
        if (m_db == nb) begin
          sa = int'($signed(m_addr));
          if (sa < -(1 << (AW - 1)) || sa >= (1 << (AW - 1))) m_ovf = 1;
          m_wa = 16'(m_addr[AW-1:0]);
          m_wd = m_word;
          exp_q.push_back({16'(1 << ch), m_wa, m_wd});
          if (m_cnt < 65535) m_cnt++;
          m_last = ch;
          m_db = 0;
          if (m_auto) m_addr = m_addr + 16'd1;
          else m_ab = 0;
        end
      end else begin
        m_err = 1; m_ab = 0; m_db = 0;
      end
    end
  endtask
  task automatic verify(input int u);
    logic [63:0] o;
    int no;
    cyc(1);
    no = u != 0 ? obs2.size() : obs.size();
    check("strobe_count", 64'(no), 64'(exp_q.size()));
    while (exp_q.size() > 0 && no > 0) begin
      if (u != 0) o = obs2.pop_front();
      else o = obs.pop_front();
      last_obs = o;
      no--;
      check("strobe", o, exp_q.pop_front());
    end
    exp_q.delete(); obs.delete(); obs2.delete();
    check("status", u != 0 ? st2 : st, mstat());
    check("wr_addr", u != 0 ? 64'(wa2) : 64'(wa), 64'(m_wa));
    check("wr_data", u != 0 ? 64'(wd2) : 64'(wd), 64'(m_wd));
  endtask
  task automatic wr(input int u, input logic [15:0] ra, input logic [7:0] b);
    mwrite(u, ra, b);
    if (u != 0) gi2 = {8'h0, 1'b0, b, ra};
    else gi = {8'h0, 1'b0, b, ra};
    cyc(1 + $urandom_range(0, 1));
    if (u != 0) gi2[24] = 1'b1;
    else gi[24] = 1'b1;
    cyc(2 + $urandom_range(0, 1));
    if (u != 0) gi2[24] = 1'b0;
    else gi[24] = 1'b0;
    cyc(3 + $urandom_range(0, 1));
    verify(u);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    gi[24] = 1'b0;
    gi2[24] = 1'b0;
    cyc(2);
    m_ab = 0; m_db = 0; m_cur = 0; m_cnt = 0; m_last = 0;
    m_err = 0; m_ovf = 0; m_auto = 0;
    m_addr = '0; m_word = '0; m_wa = '0; m_wd = '0;
    exp_q.delete(); obs.delete(); obs2.delete();
    check("rst_status", st, 64'h0);
    check("rst_status2", st2, 64'h0);
    check("rst_en", {en2, en}, 64'h0);
    check("rst_addr", {wa2, wa}, 64'h0);
    check("rst_data", {wd2, wd}, 64'h0);
    rst = 1'b1;
    cyc(1);
  endtask
  task automatic rand_ops(input int u, input int n_ops);
    int n, nb, ch, r;
    logic [7:0] hi;
    logic [15:0] ra;
    n = u != 0 ? NC2 : NC;
    nb = (u != 0 ? DW2 : DW) / 8;
    for (int i = 0; i < n_ops; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        ch = $urandom_range(0, n - 1);
        r = $urandom_range(0, 2);
        hi = r == 0 ? 8'h00 : r == 1 ? 8'hFF : 8'($urandom);
        wr(u, BASE + 16'(2 * ch), hi);
        wr(u, BASE + 16'(2 * ch), 8'($urandom));
        repeat (nb * $urandom_range(1, 2)) wr(u, BASE + 16'(2 * ch + 1), 8'($urandom));
      end else begin
        r = $urandom_range(0, 19);
        if (r == 0) ra = BASE + 16'(2 * n);
        else if (r == 1) ra = $urandom_range(0, 1) != 0 ? BASE - 16'd1 : BASE + 16'(2 * n + 1 + $urandom_range(0, 40));
        else ra = BASE + 16'(2 * ($urandom_range(0, 4) == 0 ? $urandom_range(0, n - 1) : 1) + ($urandom_range(0, 2) != 0 ? 1 : 0));
        wr(u, ra, 8'($urandom));
      end
    end
  endtask
  initial begin
    do_reset();
    wr(0, BASE + 16'd4, 8'hFF); wr(0, BASE + 16'd4, 8'h80);
    wr(0, BASE + 16'd5, 8'h12); wr(0, BASE + 16'd5, 8'h34);
    check("tp1_strobe", last_obs, {16'h0004, 16'h0080, 32'h0000_1234});
    check("tp1_count", st[15:0], 64'd1);
    check("tp1_ovf", st[17], 64'd0);
    wr(0, BASE, 8'h01); wr(0, BASE, 8'h05);
    wr(0, BASE + 16'd1, 8'hAB); wr(0, BASE + 16'd1, 8'hCD);
    check("tp2_strobe", last_obs, {16'h0001, 16'h0005, 32'h0000_ABCD});
    check("tp2_ovf", st[17], 64'd1);
    wr(0, BASE + 16'd12, 8'h03);
    wr(0, BASE + 16'd2, 8'h00); wr(0, BASE + 16'd2, 8'h7E);
    wr(0, BASE + 16'd3, 8'hAA); wr(0, BASE + 16'd3, 8'hAA);
    wr(0, BASE + 16'd3, 8'hBB); wr(0, BASE + 16'd3, 8'hBB);
    wr(0, BASE + 16'd3, 8'hCC); wr(0, BASE + 16'd3, 8'hCC);
    check("tp3_count", st[15:0], 64'd3);
    check("tp3_strobe", last_obs, {16'h0002, 16'h0080, 32'h0000_CCCC});
    check("tp3_auto", st[18], 64'd1);
    wr(0, BASE + 16'd12, 8'h01);
    wr(0, BASE + 16'd7, 8'h55);
    check("tp4_err_idle", st[16], 64'd1);
    wr(0, BASE + 16'd12, 8'h01);
    wr(0, BASE + 16'd2, 8'h11); wr(0, BASE + 16'd8, 8'h00);
    check("tp4_err_ch", st[16], 64'd1);
    wr(0, BASE + 16'd8, 8'h22);
    wr(0, BASE + 16'd9, 8'h77); wr(0, BASE + 16'd9, 8'h88);
    check("tp4_strobe", last_obs, {16'h0010, 16'h0022, 32'h0000_7788});
    check("tp4_last_ch", st[22:19], 64'd4);
    wr(0, BASE, 8'h00); wr(0, BASE, 8'h10); wr(0, BASE + 16'd1, 8'h99);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(0, BASE, 8'h00); wr(0, BASE, 8'(i));
      wr(0, BASE + 16'd1, 8'(i)); wr(0, BASE + 16'd1, 8'h5A);
    end
    wr(0, BASE + 16'd1, 8'h01);
    check("tp6_count5", st[16:0], 64'h1_0005);
    wr(0, BASE + 16'd12, 8'h01);
    check("tp6_cleared", st[18:0], 64'd0);
    rand_ops(0, 150);
    do_reset();
    wr(1, BASE + 16'd16, 8'h00); wr(1, BASE + 16'd16, 8'h10);
    wr(1, BASE + 16'd17, 8'h01); wr(1, BASE + 16'd17, 8'h02); wr(1, BASE + 16'd17, 8'h03);
    check("tp5_data", wd2, 64'h01_0203);
    check("tp5_last_ch", st2[22:19], 64'd8);
    check("tp5_strobe", last_obs, {16'h0100, 16'h0010, 32'h0001_0203});
    rand_ops(1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_lut_loader.md
# gpio_lut_loader

Hardware loader that turns the byte-wide GPIO write protocol (`{8'b0, w_clk, data[7:0], addr[15:0]}`) into word-wide writes on NUM_CH lookup tables (DAC output scalers, ADC drivers). It synchronises `w_clk`, assembles MSB-first multi-byte address and data words per channel, and issues one-cycle write strobes on a shared LUT write bus. It adds an auto-increment streaming mode, protocol-error detection and a status readback word for the `gpio_out_bus`.

## Interface
- NUM_CH, 6, number of LUT channels (1..16)
- ADDR_W, 8, LUT index width; assembled address is 16 bits, truncated to ADDR_W
- DATA_W, 16, LUT data width; multiple of 8, 8..32
- BASE_ADDR, 16'h0040, GPIO address of channel 0 addr register
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- gpio_in  in  32  [24]=w_clk (asynchronous to clk), [23:16]=data byte, [15:0]=register address
- lut_wr_en  out  NUM_CH  one-hot write strobe, one cycle
- lut_wr_addr  out  ADDR_W  LUT index, valid with lut_wr_en
- lut_wr_data  out  DATA_W  LUT word, valid with lut_wr_en
- status  out  32  [15:0] commit count, [16] seq_err, [17] addr_ovf, [18] auto_inc, [22:19] last channel, [31:23] 0

## Operation
- Register map: BASE_ADDR+2c = channel c addr reg; BASE_ADDR+2c+1 = channel c data reg; BASE_ADDR+2*NUM_CH = control reg. Other addresses are ignored.
- Control byte: bit0=1 clears the commit count, seq_err, addr_ovf and the assembly state (self-clearing). bit1 sets auto_inc, which is held until the next control write.
- `w_clk` passes through a 2-flop synchroniser plus one history flop. A write event is sync2 & ~sync3. `gpio_in[23:0]` is sampled raw on the event cycle.
- A shared assembly FSM tracks the owning channel `cur_ch`, addr byte count `ab` (0..2) and data byte count `db` (0..DATA_W/8).
  - IDLE: an addr-reg write loads the high byte, sets cur_ch, ab=1 and moves to ADDR.
  - ADDR: an addr-reg write of cur_ch loads the low byte, ab=2, moves to DATA.
  - DATA: each data-reg write of cur_ch shifts in one byte, MSB first. On the final byte the FSM moves to COMMIT.
  - COMMIT (1 cycle): pulse lut_wr_en[cur_ch] and increment the commit count (saturates at 16'hFFFF). If auto_inc=0, return to IDLE. If auto_inc=1, increment the 16-bit address (wraps 16'hFFFF→0), set db=0 and return to DATA.
- Sequence errors set seq_err (sticky). Cases:
  - data write in IDLE or ADDR;
  - write to a different channel while ADDR or DATA is in progress;
  - addr write while in DATA with db≠0.
- On an error the state restarts as if the offending write were the first:
  - an addr write is taken as the high byte;
  - any other offending write returns the FSM to IDLE.
- An addr write in DATA with db=0 is not an error; it is taken as a new high byte.
- addr_ovf (sticky) is set at commit when address bits [15:ADDR_W] are not the sign extension of bit ADDR_W-1. The write still happens, using the truncated index. This makes signed FSM values −128..127 legal for ADDR_W=8.
- A write event arriving during COMMIT is accepted in the following cycle. No event is lost, because events are at least 4 clk apart.

## Timing
- Reset values: lut_wr_en=0, lut_wr_addr=0, lut_wr_data=0, status=0, FSM=IDLE, synchroniser flops=0.
- Event latency: `w_clk` rising at the input reaches the write event 2–3 clk later.
- Write latency: final data byte event → lut_wr_en asserted the next cycle. lut_wr_addr/lut_wr_data are registered and held stable until the next commit.
- status is updated the cycle after the event or commit that changes it.
- Protocol requirement: gpio_in[23:0] is stable from at least 1 clk before `w_clk` rises until `w_clk` falls. `w_clk` is high ≥2 clk and low ≥2 clk.
- Reset asserted mid-word discards the partial word; no strobe is issued.

## Test plan
- Channel 2, default params: addr bytes 0xFF,0x80, data bytes 0x12,0x34 → one pulse lut_wr_en=6'b000100, addr=0x80, data=0x1234, count=1, addr_ovf=0.
- Address 0x01,0x05 on ch0 → lut_wr_addr=0x05, addr_ovf=1, write still issued.
- auto_inc=1, addr 0x00,0x7E on ch1, then data pairs 0xAAAA, 0xBBBB, 0xCCCC → three strobes at addresses 0x7E, 0x7F, 0x80, count=3.
- Data write to ch3 in IDLE → seq_err=1, no strobe. A ch1 addr high byte followed by a ch4 addr write → seq_err=1, assembly restarts on ch4, and a following full word commits to ch4.
- DATA_W=24, NUM_CH=9: three data bytes 0x01,0x02,0x03 on ch8 → data=0x010203, status[22:19]=8.
- Reset pulsed after one data byte → no strobe, status=0. Control write 0x01 after 5 commits → count=0 and flags cleared.
